// File: rtl/spart_pkg.sv
// Shared SPART definitions: transmitter/receiver state encoding and default frame geometry.
package spart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int SPART_OVS    = 16;
  localparam int SPART_DATA_W = 8;

endpackage

// File: rtl/spart_bit_timer.sv
// OVS-modulo tick counter: counts baud enables and flags the last enable of a bit period.
module spart_bit_timer #(
  parameter int OVS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic bit_done
);

  localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;

  logic [TW-1:0] tick;

  // OVS is a power of two, so the natural binary wrap gives the modulo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tick <= '0;
    else if (clear)
      tick <= '0;
    else if (enable)
      tick <= tick + 1'b1;
  end

  assign bit_done = enable && (tick == TW'(OVS - 1));

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: one-byte holding buffer feeding an 8N1 shift register, txd fully registered.
module spart_tx
  import spart_pkg::*;
#(
  parameter int DATA_W = SPART_DATA_W,
  parameter int OVS    = SPART_OVS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load,
  input  logic [DATA_W-1:0] tx_data,
  output logic              txd,
  output logic              tbr
);

  localparam int BW = $clog2(DATA_W) + 1;

  tx_state_t         state;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] shift;
  logic              full;
  logic [BW-1:0]     bit_idx;
  logic              bit_done;
  logic              xfer;

  // Hold->shift transfer happens from IDLE, or straight out of a finished stop bit.
  assign xfer = full && ((state == IDLE) || ((state == STOP) && bit_done));

  spart_bit_timer #(.OVS(OVS)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clear    (xfer),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      hold    <= '0;
      shift   <= '0;
      full    <= 1'b0;
      tbr     <= 1'b1;
      bit_idx <= '0;
      txd     <= 1'b1;
    end else begin
      // tbr tracks the next value of full, so a load is only seen while the buffer is empty.
      if (xfer) begin
        full <= 1'b0;
        tbr  <= 1'b1;
      end else if (load && tbr) begin
        hold <= tx_data;
        full <= 1'b1;
        tbr  <= 1'b0;
      end

      if (xfer) begin
        shift <= hold;
        state <= START;
        txd   <= 1'b0;
      end else begin
        case (state)
          START: begin
            if (bit_done) begin
              state   <= DATA;
              bit_idx <= '0;
              txd     <= shift[0];
            end
          end
          DATA: begin
            if (bit_done) begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == BW'(DATA_W - 1)) begin
                state <= STOP;
                txd   <= 1'b1;
              end else begin
                txd <= shift[1];
              end
            end
          end
          STOP: begin
            if (bit_done) begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end
          default: begin
            txd <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
